// File: rtl/memory_stage_pkg.sv
// Shared widths, opcodes, condition codes and request record for the memory stage.
// MEM_BYTE_OPS_EN (see memory_stage.sv) enables the LDB/STB opcodes defined here.
package memory_stage_pkg;

  localparam int REG_WIDTH    = 32;
  localparam int PC_WIDTH     = 16;
  localparam int IR_WIDTH     = 32;
  localparam int OPCODE_WIDTH = 8;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = 8'h3A;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h3B;
  localparam logic [OPCODE_WIDTH-1:0] OP_STB = 8'h3C;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h3D;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]     pc;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [IR_WIDTH-1:0]     ir;
    logic [3:0]              dest_idx;
    logic [REG_WIDTH-1:0]    dest_value;
    logic [2:0]              cc;
    logic [REG_WIDTH-1:0]    mar;
    logic [REG_WIDTH-1:0]    mdr;
    logic                    reg_wen;
    logic                    cc_wen;
  } mem_req_t;

  function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] v);
    if (v[REG_WIDTH-1]) begin
      return CC_N;
    end else if (v == {REG_WIDTH{1'b0}}) begin
      return CC_Z;
    end else begin
      return CC_P;
    end
  endfunction

endpackage

// File: rtl/memory_stage_dmem_ram.sv
// Word-wide data memory: one falling-edge write port with byte enables and one
// asynchronous read port sharing the same address.
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write, aligned with the pipeline's falling-edge updates
  always_ff @(negedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: word loads/stores with MEM_LATENCY-cycle access and stall.
// Define MEM_BYTE_OPS_EN to enable LDB/STB; otherwise they pass as bubbles.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DMEM_DEPTH  = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [IR_WIDTH-1:0]     I_IR,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic [2:0]              I_CCValue,
  input  logic [REG_WIDTH-1:0]    I_MARValue,
  input  logic [REG_WIDTH-1:0]    I_MDRValue,
  input  logic                    I_RegWEn,
  input  logic                    I_CCWEn,
  input  logic                    I_EX_Valid,
  output logic                    O_LOCK,
  output logic [PC_WIDTH-1:0]     O_PC,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [IR_WIDTH-1:0]     O_IR,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic [2:0]              O_CCValue,
  output logic                    O_RegWEn,
  output logic                    O_CCWEn,
  output logic                    O_MEM_Valid,
  output logic                    O_MEMStallSignal,
  output logic                    O_RegWEn_Signal,
  output logic                    O_CCWEn_Signal
);

  localparam int AW = $clog2(DMEM_DEPTH);
  localparam logic [2:0] LOAD_CNT = 3'(MEM_LATENCY - 1);

  state_t          state;
  logic [2:0]      count;
  mem_req_t        in_req, held, cur;
  logic            is_load, is_store, is_byte_op, mem_req, accept, access_now;
  logic            pass_valid, ram_we, unused_bits;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata, ram_rdata, load_val;
  logic [2:0]      load_cc;

  // Live request in IDLE, latched request while BUSY; decode and stall
  always_comb begin
    in_req = '{pc: I_PC, opcode: I_Opcode, ir: I_IR, dest_idx: I_DestRegIdx,
               dest_value: I_DestValue, cc: I_CCValue, mar: I_MARValue,
               mdr: I_MDRValue, reg_wen: I_RegWEn, cc_wen: I_CCWEn};
    if (state == S_BUSY) begin
      cur = held;
    end else begin
      cur = in_req;
    end
    is_byte_op = (cur.opcode == OP_LDB) || (cur.opcode == OP_STB);
`ifdef MEM_BYTE_OPS_EN
    is_load  = (cur.opcode == OP_LDW) || (cur.opcode == OP_LDB);
    is_store = (cur.opcode == OP_STW) || (cur.opcode == OP_STB);
`else
    is_load  = (cur.opcode == OP_LDW);
    is_store = (cur.opcode == OP_STW);
`endif
    mem_req    = (state == S_IDLE) && I_LOCK && I_EX_Valid && (is_load || is_store);
    accept     = mem_req && (MEM_LATENCY > 1);
    access_now = (mem_req && (MEM_LATENCY == 1)) || ((state == S_BUSY) && (count == 3'd1));
    pass_valid = I_EX_Valid && !is_byte_op;
    ram_we     = access_now && is_store && !I_RESET;
    O_MEMStallSignal = !I_RESET && (accept || (state == S_BUSY));
    if (state == S_BUSY) begin
      O_RegWEn_Signal = is_load;
      O_CCWEn_Signal  = is_load;
    end else if (is_load || is_store) begin
      O_RegWEn_Signal = I_EX_Valid && is_load;
      O_CCWEn_Signal  = I_EX_Valid && is_load;
    end else begin
      O_RegWEn_Signal = pass_valid && cur.reg_wen;
      O_CCWEn_Signal  = pass_valid && cur.cc_wen;
    end
    unused_bits = ^{cur.mar[REG_WIDTH-1:AW+2], cur.mar[1:0]};
  end

  // Byte-lane steering for stores and sign-extended byte loads
  always_comb begin
    ram_be    = 4'hF;
    ram_wdata = cur.mdr;
    load_val  = ram_rdata;
`ifdef MEM_BYTE_OPS_EN
    if (is_byte_op) begin
      ram_be    = 4'b0001 << cur.mar[1:0];
      ram_wdata = {4{cur.mdr[7:0]}};
      load_val  = {{24{ram_rdata[{cur.mar[1:0], 3'b111}]}},
                   ram_rdata[{cur.mar[1:0], 3'b000} +: 8]};
    end else begin
      ram_be    = 4'hF;
      ram_wdata = cur.mdr;
      load_val  = ram_rdata;
    end
`endif
    load_cc = cc_of(load_val);
  end

  dmem_ram #(.DEPTH(DMEM_DEPTH), .AW(AW)) u_dmem (
    .clk   (I_CLOCK),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (cur.mar[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Writeback register, IDLE/BUSY FSM and latency down-counter
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      state        <= S_IDLE;
      count        <= 3'd0;
      held         <= '0;
      O_LOCK       <= 1'b0;
      O_PC         <= '0;
      O_Opcode     <= '0;
      O_IR         <= '0;
      O_DestRegIdx <= 4'd0;
      O_DestValue  <= '0;
      O_CCValue    <= CC_Z;
      O_RegWEn     <= 1'b0;
      O_CCWEn      <= 1'b0;
      O_MEM_Valid  <= 1'b0;
    end else begin
      O_LOCK <= I_LOCK;
      if (access_now) begin
        O_PC         <= cur.pc;
        O_Opcode     <= cur.opcode;
        O_IR         <= cur.ir;
        O_DestRegIdx <= cur.dest_idx;
        O_DestValue  <= is_load ? load_val : cur.dest_value;
        O_CCValue    <= is_load ? load_cc : cur.cc;
        O_MEM_Valid  <= 1'b1;
        O_RegWEn     <= is_load;
        O_CCWEn      <= is_load;
      end else if ((state == S_BUSY) || accept || !I_LOCK) begin
        O_MEM_Valid  <= 1'b0;
        O_RegWEn     <= 1'b0;
        O_CCWEn      <= 1'b0;
      end else begin
        O_PC         <= cur.pc;
        O_Opcode     <= cur.opcode;
        O_IR         <= cur.ir;
        O_DestRegIdx <= cur.dest_idx;
        O_DestValue  <= cur.dest_value;
        O_CCValue    <= cur.cc;
        O_MEM_Valid  <= pass_valid;
        O_RegWEn     <= pass_valid && cur.reg_wen;
        O_CCWEn      <= pass_valid && cur.cc_wen;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            held  <= in_req;
            count <= LOAD_CNT;
            state <= S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          count <= count - 3'd1;
          if (count == 3'd1) begin
            state <= S_IDLE;
          end else begin
            state <= S_BUSY;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= 3'd0;
        end
      endcase
    end
  end

endmodule
